// File: rtl/sp_com_align_if.sv
// Lane-side bundle for sp_com_align: serial bit in, aligned byte strobe and link status out.
// The slave side is the aligner; the master side drives the serial bit and observes the results.
interface sp_com_align_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [2:0] com_count;

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output com_count
    );

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  com_count
    );
endinterface

// File: rtl/sp_com_align.sv
// Serial-to-parallel comma aligner: hunts COM bit-by-bit, trains on COM_NEEDED COMs, then emits data bytes.
// Latency: a byte is registered on the edge sampling its 8th bit. There is no backpressure; valid_out is a strobe.
module sp_com_align #(
    parameter int         COM_NEEDED = 4,
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDL_SYM    = 8'h7C
) (
    input  logic          clk32f,
    input  logic          reset,
    sp_com_align_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] COM_MAX = 3'(COM_NEEDED);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] com_count_q, com_count_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       active_q, active_d;

    logic [7:0] cand;
    logic [2:0] com_inc;
    logic       boundary;

    always_comb begin
        cand        = {sr_q[6:0], bus.data_in};
        com_inc     = com_count_q + 3'd1;
        boundary    = (bit_cnt_q == 3'd7);
        state_d     = state_q;
        sr_d        = cand;
        bit_cnt_d   = bit_cnt_q;
        com_count_d = com_count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        active_d    = active_q;

        unique case (state_q)
            HUNT: begin
                if (cand == COM_SYM) begin
                    bit_cnt_d   = 3'd0;
                    com_count_d = 3'd1;
                    if (COM_MAX <= 3'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (cand == COM_SYM) begin
                        com_count_d = com_inc;
                        if (com_inc >= COM_MAX) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Lost lock: bit-granular search resumes on the very next edge.
                        state_d     = HUNT;
                        com_count_d = 3'd0;
                        bit_cnt_d   = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary && (cand != COM_SYM) && (cand != IDL_SYM)) begin
                    data_out_d  = cand;
                    valid_out_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            com_count_q <= 3'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_count_q <= com_count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.active    = active_q;
    assign bus.com_count = com_count_q;

endmodule

// File: tb/tb_sp_com_align.sv
// Directed bench for sp_com_align: every scenario runs against a COM_NEEDED=4 and a COM_NEEDED=2 instance.
// The instance not under test is held in reset; inputs change 1ns after the rising edge, outputs are sampled there too.
module tb_sp_com_align;

    logic clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    logic rst = 1'b1;
    int   sel = 0;
    logic din = 1'b0;
    logic rst4, rst2;

    assign rst4 = rst || (sel != 0);
    assign rst2 = rst || (sel != 1);

    sp_com_align_if if4 ();
    sp_com_align_if if2 ();

    assign if4.data_in = din;
    assign if2.data_in = din;

    sp_com_align #(.COM_NEEDED(4)) dut4 (
        .clk32f (clk32f),
        .reset  (rst4),
        .bus    (if4)
    );

    sp_com_align #(.COM_NEEDED(2)) dut2 (
        .clk32f (clk32f),
        .reset  (rst2),
        .bus    (if2)
    );

    logic [7:0] o_data, o_vld, o_act, o_cnt;

    always_comb begin
        if (sel == 1) begin
            o_data = if2.data_out;
            o_vld  = {7'd0, if2.valid_out};
            o_act  = {7'd0, if2.active};
            o_cnt  = {5'd0, if2.com_count};
        end else begin
            o_data = if4.data_out;
            o_vld  = {7'd0, if4.valid_out};
            o_act  = {7'd0, if4.active};
            o_cnt  = {5'd0, if4.com_count};
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int n_need   = 4;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (N=%0d): observed %h expected %h", tag, n_need, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk32f);
        #1;
    endtask

    // Serialises a byte MSB first; valid_out must be high only after the 8th bit, and only if expected.
    task automatic send_byte(input logic [7:0] b, input logic exp_vld);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            chk("valid_per_bit", o_vld, {7'd0, (exp_vld && (i == 0))});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b0;
    endtask

    task automatic train(input string tag);
        for (int j = 1; j <= n_need; j++) begin
            send_byte(8'hBC, 1'b0);
            chk({tag, "_cnt"}, o_cnt, 8'(j));
            chk({tag, "_act"}, o_act, {7'd0, (j == n_need)});
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sel    = k;
            n_need = (k == 0) ? 4 : 2;

            // Basic training then one data byte.
            do_reset();
            chk("rst_data", o_data, 8'h00);
            chk("rst_vld",  o_vld,  8'd0);
            chk("rst_act",  o_act,  8'd0);
            chk("rst_cnt",  o_cnt,  8'd0);
            train("basic");
            send_byte(8'hA5, 1'b1);
            chk("basic_data", o_data, 8'hA5);
            chk("basic_cnt",  o_cnt,  8'(n_need));

            // Alignment at a 3-bit offset.
            do_reset();
            send_bit(1'b1);
            send_bit(1'b0);
            send_bit(1'b1);
            chk("off_pre_cnt", o_cnt, 8'd0);
            chk("off_pre_act", o_act, 8'd0);
            train("off");
            send_byte(8'h12, 1'b1);
            chk("off_data", o_data, 8'h12);
            chk("off_cnt",  o_cnt,  8'(n_need));

            // One COM short, then a data byte breaks lock.
            do_reset();
            for (int j = 1; j < n_need; j++) begin
                send_byte(8'hBC, 1'b0);
                chk("brk_cnt", o_cnt, 8'(j));
                chk("brk_act", o_act, 8'd0);
            end
            send_byte(8'h55, 1'b0);
            chk("brk_lost_cnt",  o_cnt,  8'd0);
            chk("brk_lost_act",  o_act,  8'd0);
            chk("brk_lost_data", o_data, 8'h00);
            train("retrain");
            send_byte(8'h5A, 1'b1);
            chk("retrain_data", o_data, 8'h5A);

            // Idle and comma suppression on an active link.
            send_byte(8'h7C, 1'b0);
            chk("idle_hold", o_data, 8'h5A);
            send_byte(8'hBC, 1'b0);
            chk("com_hold", o_data, 8'h5A);
            chk("com_sat",  o_cnt,  8'(n_need));
            send_byte(8'h99, 1'b1);
            chk("sup_data", o_data, 8'h99);
            send_byte(8'h7C, 1'b0);
            chk("sup_hold", o_data, 8'h99);
            chk("sup_act",  o_act,  8'd1);

            // Reset mid-byte on an active link.
            send_bit(1'b0);
            send_bit(1'b0);
            send_bit(1'b0);
            send_bit(1'b1);
            rst = 1'b1;
            send_bit(1'b0);
            rst = 1'b0;
            chk("mid_rst_data", o_data, 8'h00);
            chk("mid_rst_vld",  o_vld,  8'd0);
            chk("mid_rst_act",  o_act,  8'd0);
            chk("mid_rst_cnt",  o_cnt,  8'd0);
            train("post_rst");
            send_byte(8'hFF, 1'b1);
            chk("post_rst_data", o_data, 8'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
